// File: rtl/apb_master_bridge_if.sv
// Bundle of the command, response and APB signals around apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the view of
// whatever drives commands and implements the APB completer.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // Response port
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  // APB3 bus
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 requester: takes one command at a time from a valid/ready port, runs it
// as a single SETUP/ACCESS transfer and returns the result on a valid/ready
// response port. A bounded wait-state counter aborts transfers to a completer
// that never raises pready (TIMEOUT=0 disables the abort).
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_master_bridge_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Counter is at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;

  // The only combinational output: a command is taken whenever the bridge is idle.
  assign bus.cmd_ready = (state_q == IDLE);

  // Next-state and next-output logic for the transfer sequence.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    wait_d        = wait_q;
    psel_d        = bus.psel;
    penable_d     = bus.penable;
    pwrite_d      = bus.pwrite;
    paddr_d       = bus.paddr;
    pwdata_d      = bus.pwdata;
    rsp_valid_d   = bus.rsp_valid;
    rsp_rdata_d   = bus.rsp_rdata;
    rsp_err_d     = bus.rsp_err;
    rsp_timeout_d = bus.rsp_timeout;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          // Reads leave the previous write data on pwdata.
          if (bus.cmd_write) pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (bus.pready) begin
          // Completion wins even on the cycle the timeout would have fired.
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = bus.pwrite ? '0 : bus.prdata;
          state_d       = RESP;
        end else if (TIMEOUT != 0) begin
          wait_d = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_W'(1);
          if (wait_q == CNT_LAST) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            state_d       = RESP;
          end
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, wait counter and all registered outputs; reset aborts any transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q         <= IDLE;
      wait_q          <= '0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q         <= state_d;
      wait_q          <= wait_d;
      bus.psel        <= psel_d;
      bus.penable     <= penable_d;
      bus.pwrite      <= pwrite_d;
      bus.paddr       <= paddr_d;
      bus.pwdata      <= pwdata_d;
      bus.rsp_valid   <= rsp_valid_d;
      bus.rsp_rdata   <= rsp_rdata_d;
      bus.rsp_err     <= rsp_err_d;
      bus.rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with TIMEOUT=4. A small APB completer
// model (16-word memory, programmable wait states, error and stall) sits on
// the slave side. Table vectors cover completions, errors and timeouts; hand
// sequences cover throughput, response backpressure and reset mid-transfer.
module tb_apb_master_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int MAX_CYC = 20;

  logic pclk = 1'b0;
  logic presetn;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  // Completer model configuration, changed only between transfers.
  int          cfg_waits = 0;
  logic        cfg_err   = 1'b0;
  logic        cfg_stall = 1'b0;
  int          acc_cnt   = 0;
  logic [31:0] mem [16]  = '{default: 32'h0};

  assign bus.pready  = bus.psel && bus.penable && !cfg_stall && (acc_cnt == cfg_waits);
  assign bus.pslverr = cfg_err;
  assign bus.prdata  = cfg_err ? 32'h0 : mem[bus.paddr[3:0]];

  // Counts wait states of the current ACCESS phase; stores error-free writes.
  always @(posedge pclk) begin
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else                                        acc_cnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && !cfg_err)
      mem[bus.paddr[3:0]] <= bus.pwdata;
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] last_wdata = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic        stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  // Issues one command from a negedge in IDLE, follows it to the response
  // (rsp_ready assumed 1) and returns at the negedge after it is consumed.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int stab_bad;
    cfg_waits = v.waits;
    cfg_err   = v.err;
    cfg_stall = v.stall;
    if (v.write) last_wdata = v.wdata;
    check({tag, " cmd_ready idle"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    cyc = 1;
    check({tag, " setup psel/penable"}, 64'({bus.psel, bus.penable}), 64'b10);
    stab_bad = 0;
    while (!bus.rsp_valid && cyc < MAX_CYC) begin
      if (cyc >= 2 && ({bus.psel, bus.penable} != 2'b11 || bus.paddr != v.addr ||
                       bus.pwrite != v.write || bus.pwdata != last_wdata))
        stab_bad++;
      @(negedge pclk);
      cyc++;
    end
    check({tag, " access stability"}, 64'(stab_bad), 64'd0);
    check({tag, " latency"}, 64'(cyc), 64'(v.exp_lat));
    check({tag, " rsp_rdata"}, 64'(bus.rsp_rdata), 64'(v.exp_rdata));
    check({tag, " rsp_err/timeout"}, 64'({bus.rsp_err, bus.rsp_timeout}),
          64'({v.exp_err, v.exp_to}));
    check({tag, " bus idle at rsp"}, 64'({bus.psel, bus.penable}), 64'b00);
    @(negedge pclk);
    check({tag, " consumed"}, 64'({bus.rsp_valid, bus.cmd_ready}), 64'b01);
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int accepts;
    int bp_bad;
    vec_t v;

    //            wr    addr   wdata         wt err stl exp_rdata     err to lat
    vecs[0] = '{1'b1, 32'h3, 32'h0000_0005, 0, 0, 0, 32'h0,        0, 0, 3};
    vecs[1] = '{1'b0, 32'h3, 32'hFFFF_FFFF, 0, 0, 0, 32'h5,        0, 0, 3};
    vecs[2] = '{1'b1, 32'h7, 32'hDEAD_BEEF, 3, 0, 0, 32'h0,        0, 0, 6};
    vecs[3] = '{1'b0, 32'h7, 32'h1111_1111, 3, 0, 0, 32'hDEAD_BEEF, 0, 0, 6};
    vecs[4] = '{1'b0, 32'h3, 32'h2222_2222, 0, 1, 0, 32'h0,        1, 0, 3};
    vecs[5] = '{1'b1, 32'h9, 32'h0000_1234, 1, 1, 0, 32'h0,        1, 0, 4};
    vecs[6] = '{1'b0, 32'h9, 32'h3333_3333, 0, 0, 0, 32'h0,        0, 0, 3};
    vecs[7] = '{1'b1, 32'h2, 32'h0000_A5A5, 0, 0, 1, 32'h0,        1, 1, 6};
    vecs[8] = '{1'b0, 32'h2, 32'h4444_4444, 4, 0, 0, 32'h0,        1, 1, 6};
    vecs[9] = '{1'b0, 32'h7, 32'h5555_5555, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 3};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    presetn       = 1'b0;
    repeat (2) @(negedge pclk);
    check("reset outputs",
          64'({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err,
               bus.rsp_timeout, bus.cmd_ready}), 64'b0000001);
    check("reset paddr/pwdata", {bus.paddr, bus.pwdata}, 64'h0);
    check("reset rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    presetn = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back reads with cmd_valid held: one acceptance every 4 cycles.
    cfg_waits = 0; cfg_err = 1'b0; cfg_stall = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h3;
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.cmd_valid && bus.cmd_ready) accepts++;
      @(negedge pclk);
    end
    bus.cmd_valid = 1'b0;
    check("throughput accepts in 12 cycles", 64'(accepts), 64'd3);
    check("throughput idle after", 64'(bus.cmd_ready), 64'd1);

    // Response held off for 5 cycles while a new command is offered.
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h3;
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < MAX_CYC && !bus.rsp_valid; i++) @(negedge pclk);
    check("backpressure rsp arrives", 64'(bus.rsp_valid), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h7;
    bp_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (bus.cmd_ready || bus.psel || !bus.rsp_valid || bus.rsp_rdata != 32'h5) bp_bad++;
    end
    check("backpressure hold", 64'(bp_bad), 64'd0);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    check("backpressure release", 64'({bus.rsp_valid, bus.cmd_ready, bus.psel}), 64'b010);

    // Asynchronous reset in the middle of an ACCESS phase.
    cfg_stall = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h5;
    bus.cmd_wdata = 32'h77;
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    check("pre-reset access", 64'({bus.psel, bus.penable}), 64'b11);
    #2 presetn = 1'b0;
    #1;
    check("mid-access reset", 64'({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}),
          64'b0001);
    @(negedge pclk);
    presetn    = 1'b1;
    cfg_stall  = 1'b0;
    last_wdata = 32'h0;
    @(negedge pclk);
    v = '{1'b0, 32'h5, 32'h6666_6666, 0, 0, 0, 32'h0, 0, 0, 3};
    run_vec(v, "post-reset aborted write");
    v = '{1'b0, 32'h3, 32'h0, 1, 0, 0, 32'h5, 0, 0, 4};
    run_vec(v, "post-reset read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
